// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the MIPS core (port C) and a
// host/loader port (port H). Sticky grant with a burst limit so neither side starves.
//
// Ports:
//   clk, reset                  clock; asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   core request, write enable, byte address, write data
//   c_gnt                       core access accepted this cycle (combinational)
//   c_rvalid/c_rdata            core read data, valid the cycle after a read grant
//   h_*                         same set for the host port
//   mem_we/mem_a/mem_wd         to dmem.we / dmem.a / dmem.wd
//   mem_rd                      from dmem.rd (combinational read)
//   owner                       last granted port (0 = core, 1 = host)
//   err                         one-cycle pulse after a rejected access
//
// Optional feature: define DMEM_ARB_ADDR_CHECK_EN to reject granted accesses whose word
// address addr[15:1] is >= DEPTH (write suppressed, rvalid with zero data, err pulse).

module dmem_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [15:0] c_rdata,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [15:0] h_addr,
  input  logic [15:0] h_wdata,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [15:0] h_rdata,
  output logic        mem_we,
  output logic [15:0] mem_a,
  output logic [15:0] mem_wd,
  input  logic [15:0] mem_rd,
  output logic        owner,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StOwnC, StOwnH} state_e;

  localparam logic [3:0] BurstMax = 4'(BURST_MAX);

  state_e      state_q, state_d;
  logic [3:0]  burst_cnt_q, burst_cnt_d;
  logic        owner_q, owner_d;
  logic        c_gnt_raw, h_gnt_raw;
  logic [3:0]  cnt_inc;
  logic        under_limit;

  logic        any_gnt;
  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wd;
  logic        oob;

  logic        c_rvalid_q, h_rvalid_q, err_q;
  logic [15:0] c_rdata_q, h_rdata_q;

  assign cnt_inc     = (burst_cnt_q == 4'hf) ? 4'hf : burst_cnt_q + 4'd1;
  assign under_limit = (burst_cnt_q < BurstMax);

  // Arbitration: grant and next state derived from current owner and both requests.
  always_comb begin
    c_gnt_raw   = 1'b0;
    h_gnt_raw   = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (c_req) begin
          c_gnt_raw   = 1'b1;
          state_d     = StOwnC;
          burst_cnt_d = 4'd1;
        end else if (h_req) begin
          h_gnt_raw   = 1'b1;
          state_d     = StOwnH;
          burst_cnt_d = 4'd1;
        end
      end
      StOwnC: begin
        if (c_req && (under_limit || !h_req)) begin
          c_gnt_raw   = 1'b1;
          burst_cnt_d = cnt_inc;
        end else if (h_req) begin
          h_gnt_raw   = 1'b1;
          state_d     = StOwnH;
          burst_cnt_d = 4'd1;
        end else begin
          state_d     = StIdle;
          burst_cnt_d = 4'd0;
        end
      end
      StOwnH: begin
        if (h_req && (under_limit || !c_req)) begin
          h_gnt_raw   = 1'b1;
          burst_cnt_d = cnt_inc;
        end else if (c_req) begin
          c_gnt_raw   = 1'b1;
          state_d     = StOwnC;
          burst_cnt_d = 4'd1;
        end else begin
          state_d     = StIdle;
          burst_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d     = StIdle;
        burst_cnt_d = 4'd0;
      end
    endcase
  end

  // Grants are gated by reset so nothing reaches dmem while reset is held low.
  assign c_gnt   = c_gnt_raw & reset;
  assign h_gnt   = h_gnt_raw & reset;
  assign any_gnt = c_gnt | h_gnt;

  always_comb begin
    owner_d = owner_q;
    if (c_gnt) begin
      owner_d = 1'b0;
    end else if (h_gnt) begin
      owner_d = 1'b1;
    end
  end

  // With no grant the core's address/data sit on the bus (we is still held low).
  assign sel_we   = h_gnt ? h_we    : c_we;
  assign sel_addr = h_gnt ? h_addr  : c_addr;
  assign sel_wd   = h_gnt ? h_wdata : c_wdata;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign oob = any_gnt && ({17'b0, sel_addr[15:1]} >= DEPTH);
`else
  assign oob = 1'b0;
`endif

  assign mem_we = any_gnt & sel_we & ~oob;
  assign mem_a  = sel_addr;
  assign mem_wd = sel_wd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      burst_cnt_q <= 4'd0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      owner_q     <= owner_d;
    end
  end

  // Read return path. A rejected access returns zero data with rvalid, even for writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rdata_q  <= 16'h0000;
      h_rdata_q  <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      c_rvalid_q <= c_gnt & (~c_we | oob);
      h_rvalid_q <= h_gnt & (~h_we | oob);
      err_q      <= oob;
      if (c_gnt && oob) begin
        c_rdata_q <= 16'h0000;
      end else if (c_gnt && !c_we) begin
        c_rdata_q <= mem_rd;
      end
      if (h_gnt && oob) begin
        h_rdata_q <= 16'h0000;
      end else if (h_gnt && !h_we) begin
        h_rdata_q <= mem_rd;
      end
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign h_rvalid = h_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign h_rdata  = h_rdata_q;
  assign owner    = owner_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural dmem attached.
module tb_dmem_arbiter;

  localparam int unsigned Depth = 64;

  logic        clk;
  logic        reset;
  logic        c_req, c_we, h_req, h_we;
  logic [15:0] c_addr, c_wdata, h_addr, h_wdata;
  logic        c_gnt, h_gnt, c_rvalid, h_rvalid;
  logic [15:0] c_rdata, h_rdata;
  logic        mem_we;
  logic [15:0] mem_a, mem_wd, mem_rd;
  logic        owner, err;

  dmem_arbiter #(
    .BURST_MAX (4),
    .DEPTH     (Depth)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .c_req    (c_req),
    .c_we     (c_we),
    .c_addr   (c_addr),
    .c_wdata  (c_wdata),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_gnt    (h_gnt),
    .h_rvalid (h_rvalid),
    .h_rdata  (h_rdata),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd),
    .owner    (owner),
    .err      (err)
  );

  // Behavioural dmem: combinational read, write at the clock edge.
  logic [15:0] mem [64];
  assign mem_rd = mem[mem_a[6:1]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_a[6:1]] <= mem_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        c_rv;
    logic        h_rv;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_mem [64];
  logic [15:0] last_c, last_h;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle, entered just after a negedge: drive, check grant/bus, push the
  // expected return; then after the posedge pop and check it. Ends at the next negedge.
  task automatic step(input logic cr, input logic cw, input logic [15:0] ca,
                      input logic [15:0] cd, input logic hr, input logic hw,
                      input logic [15:0] ha, input logic [15:0] hd,
                      input logic eg_c, input logic eg_h);
    exp_t        e;
    logic        oob;
    logic        we;
    logic [15:0] a, d;
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    #1;
    check_eq("c_gnt", {15'b0, c_gnt}, {15'b0, eg_c});
    check_eq("h_gnt", {15'b0, h_gnt}, {15'b0, eg_h});
    we = eg_h ? hw : cw;
    a  = eg_h ? ha : ca;
    d  = eg_h ? hd : cd;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    oob = (eg_c | eg_h) && ({17'b0, a[15:1]} >= Depth);
`else
    oob = 1'b0;
`endif
    e = '0;
    check_eq("mem_a", mem_a, a);
    check_eq("mem_we", {15'b0, mem_we}, {15'b0, (eg_c | eg_h) & we & ~oob});
    if (eg_c | eg_h) begin
      if (we) check_eq("mem_wd", mem_wd, d);
      e.c_rv = eg_c & (~we | oob);
      e.h_rv = eg_h & (~we | oob);
      e.err  = oob;
      e.data = oob ? 16'h0000 : model_mem[a[6:1]];
      if (we && !oob) model_mem[a[6:1]] = d;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (e.c_rv) last_c = e.data;
    if (e.h_rv) last_h = e.data;
    check_eq("c_rvalid", {15'b0, c_rvalid}, {15'b0, e.c_rv});
    check_eq("h_rvalid", {15'b0, h_rvalid}, {15'b0, e.h_rv});
    check_eq("c_rdata", c_rdata, last_c);
    check_eq("h_rdata", h_rdata, last_h);
    check_eq("err", {15'b0, err}, {15'b0, e.err});
    @(negedge clk);
  endtask

  task automatic check_owner(input logic exp);
    check_eq("owner", {15'b0, owner}, {15'b0, exp});
  endtask

  logic [15:0] host_addrs [10];
  logic        exp_c;

  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = 16'h0000;
    last_c = 16'h0000;
    last_h = 16'h0000;
    host_addrs[0] = 16'h0028; host_addrs[1] = 16'h002A; host_addrs[2] = 16'h002C;
    host_addrs[3] = 16'h002E; host_addrs[4] = 16'h0000; host_addrs[5] = 16'h0002;
    host_addrs[6] = 16'h0004; host_addrs[7] = 16'h0006; host_addrs[8] = 16'h0010;
    host_addrs[9] = 16'h0030;

    // Reset held with both ports requesting writes.
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0000; c_wdata = 16'hC000;
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0020; h_wdata = 16'hD000;
    repeat (3) @(negedge clk);
    check_eq("rst c_gnt", {15'b0, c_gnt}, 16'h0);
    check_eq("rst h_gnt", {15'b0, h_gnt}, 16'h0);
    check_eq("rst mem_we", {15'b0, mem_we}, 16'h0);
    check_eq("rst owner", {15'b0, owner}, 16'h0);
    check_eq("rst c_rvalid", {15'b0, c_rvalid}, 16'h0);
    check_eq("rst h_rvalid", {15'b0, h_rvalid}, 16'h0);
    check_eq("rst c_rdata", c_rdata, 16'h0);
    check_eq("rst h_rdata", h_rdata, 16'h0);
    check_eq("rst err", {15'b0, err}, 16'h0);

    // Release and contend: C x4, H x4, C x4.
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_c = ((i / 4) % 2) == 0;
      step(1'b1, 1'b1, 16'(2 * (i % 8)), 16'(16'hC000 + i),
           1'b1, 1'b1, 16'(32 + 2 * (i % 8)), 16'(16'hD000 + i), exp_c, ~exp_c);
      check_owner(~exp_c);
    end

    // Idle cycle: no grant, owner keeps last value.
    step(1'b0, 1'b0, 16'h0004, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check_owner(1'b0);

    // Core write then read back.
    step(1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Host write, core reads it back (ownership moves H -> C).
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0030, 16'hBEEF, 1'b0, 1'b1);
    check_owner(1'b1);
    step(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    check_owner(1'b0);

    // Host alone: 10 back-to-back reads, no burst limit without contention.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, host_addrs[i], 16'h0, 1'b0, 1'b1);
    end
    // Host past its limit: a core request wins at once.
    step(1'b1, 1'b0, 16'h0002, 16'h0, 1'b1, 1'b0, 16'h0004, 16'h0, 1'b1, 1'b0);
    check_owner(1'b0);

    // Reset in the cycle after a host read grant.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0028, 16'h0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("midrst h_rvalid", {15'b0, h_rvalid}, 16'h0);
    check_eq("midrst h_rdata", h_rdata, 16'h0);
    check_eq("midrst h_gnt", {15'b0, h_gnt}, 16'h0);
    check_eq("midrst owner", {15'b0, owner}, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    last_c = 16'h0000;
    last_h = 16'h0000;
    // Back in IDLE: core wins a simultaneous request.
    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0028, 16'h0, 1'b1, 1'b0);
    check_owner(1'b0);

`ifdef DMEM_ARB_ADDR_CHECK_EN
    // Out-of-range host write is dropped; word 0 keeps its contents.
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0080, 16'hDEAD, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0080, 16'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
